// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package mole_game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPAWN  = 2'd1,
    ACTIVE = 2'd2,
    OVER   = 2'd3
  } mg_state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over q[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mg_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick the next mole hole.
module mg_lfsr16
  import mole_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/mole_game_engine.sv
// Whack-a-mole game core: spawns timed moles, scores edge-qualified hits,
// counts misses and applies an accumulating per-hole penalty lockout.
module mole_game_engine
  import mole_game_pkg::*;
#(
  parameter int          NUM_HOLES   = 8,
  parameter int          SCORE_W     = 8,
  parameter int          GAME_CYCLES = 15_000_000,
  parameter int          MOLE_CYCLES = 500_000,
  parameter int          LOCK_CYCLES = 1_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] btn,
  input  logic [1:0]           level,
  output logic [NUM_HOLES-1:0] mole,
  output logic [NUM_HOLES-1:0] lockout,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 game_over,
  output logic [1:0]           state_o
);

  localparam int IDX_W  = $clog2(NUM_HOLES);
  localparam int GAME_W = $clog2(GAME_CYCLES + 1);
  localparam int MOLE_W = $clog2(MOLE_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  mg_state_t state, state_d;

  logic                 start_q;
  logic [NUM_HOLES-1:0] btn_q;
  logic [NUM_HOLES-1:0] mole_d, lockout_d;
  logic [SCORE_W-1:0]   score_d, misses_d, score_inc, misses_inc;
  logic [GAME_W-1:0]    game_t, game_d;
  logic [MOLE_W-1:0]    mole_t, mole_t_d;
  logic [LOCK_W-1:0]    lock_t, lock_t_d;
  logic [IDX_W-1:0]     prev, prev_d, cand;
  logic [15:0]          lfsr_q;
  logic                 unused_lfsr;

  logic                 start_rise, hit, wrong, game_exp, mole_exp, cand_ok;
  logic                 go_over, do_restart;
  logic [NUM_HOLES-1:0] press, wrong_bits;

  mg_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:IDX_W];

  assign start_rise = start & ~start_q;
  assign press      = btn & ~btn_q & ~lockout;
  assign hit        = |(press & mole);
  assign wrong_bits = press & ~mole;
  assign wrong      = |wrong_bits;

  // Timers expire on the cycle they would step from 1 to 0
  assign game_exp = (game_t <= GAME_W'(1));
  assign mole_exp = (mole_t <= MOLE_W'(1));

  assign cand    = lfsr_q[IDX_W-1:0];
  assign cand_ok = (int'(cand) < NUM_HOLES) && (cand != prev);

  assign score_inc  = (score == '1)  ? score  : score + 1'b1;
  assign misses_inc = (misses == '1) ? misses : misses + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      btn_q   <= '0;
      mole    <= '0;
      lockout <= '0;
      score   <= '0;
      misses  <= '0;
      game_t  <= '0;
      mole_t  <= '0;
      lock_t  <= '0;
      prev    <= '0;
    end else begin
      state   <= state_d;
      start_q <= start;
      btn_q   <= btn;
      mole    <= mole_d;
      lockout <= lockout_d;
      score   <= score_d;
      misses  <= misses_d;
      game_t  <= game_d;
      mole_t  <= mole_t_d;
      lock_t  <= lock_t_d;
      prev    <= prev_d;
    end
  end

  always_comb begin
    state_d    = state;
    mole_d     = mole;
    lockout_d  = lockout;
    score_d    = score;
    misses_d   = misses;
    game_d     = game_t;
    mole_t_d   = mole_t;
    lock_t_d   = lock_t;
    prev_d     = prev;
    go_over    = 1'b0;
    do_restart = 1'b0;

    // Lockout timer freezes in OVER so the all-ones mask stays put
    if (state != OVER && lock_t != '0) begin
      lock_t_d = lock_t - 1'b1;
      if (lock_t == LOCK_W'(1)) begin
        lockout_d = '0;
      end
    end

    if ((state == SPAWN || state == ACTIVE) && game_t != '0) begin
      game_d = game_t - 1'b1;
    end

    if (state == ACTIVE && mole_t != '0) begin
      mole_t_d = mole_t - 1'b1;
    end

    case (state)
      SPAWN: begin
        if (game_exp) begin
          go_over = 1'b1;
        end else if (start_rise) begin
          do_restart = 1'b1;
        end else if (cand_ok) begin
          mole_d   = NUM_HOLES'(1) << cand;
          prev_d   = cand;
          mole_t_d = MOLE_W'(MOLE_CYCLES >> level);
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (game_exp) begin
          go_over = 1'b1;
        end else if (start_rise) begin
          do_restart = 1'b1;
        end else if (hit) begin
          score_d = score_inc;
          mole_d  = '0;
          state_d = SPAWN;
        end else if (wrong) begin
          // A reload keeps every bit already locked, even on the expiry cycle
          misses_d  = misses_inc;
          lockout_d = lockout | wrong_bits;
          lock_t_d  = LOCK_W'(LOCK_CYCLES);
        end else if (mole_exp) begin
          misses_d = misses_inc;
          mole_d   = '0;
          state_d  = SPAWN;
        end
      end
      default: begin
        if (start_rise) begin
          do_restart = 1'b1;
        end
      end
    endcase

    if (go_over) begin
      state_d   = OVER;
      mole_d    = '0;
      lockout_d = '1;
    end

    if (do_restart) begin
      state_d   = SPAWN;
      mole_d    = '0;
      score_d   = '0;
      misses_d  = '0;
      lockout_d = '0;
      lock_t_d  = '0;
      game_d    = GAME_W'(GAME_CYCLES);
    end
  end

  assign game_over = (state == OVER);
  assign state_o   = state;

endmodule

// File: tb/tb_mole_game_engine.sv
// Self-checking bench: behavioural game model compared every cycle, plus directed scenarios.
module tb_mole_game_engine;

  localparam int NH    = 8;
  localparam int SW    = 2;
  localparam int GAME  = 400;
  localparam int MOLE  = 40;
  localparam int LOCK  = 10;
  localparam int SMAX  = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NH-1:0] btn   = '0;
  logic [1:0]    level = 2'd0;

  logic [NH-1:0] mole, lockout;
  logic [SW-1:0] score, misses;
  logic          game_over;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 spawn, 2 active, 3 over
  int          m_state     = 0;
  int          m_score     = 0;
  int          m_misses    = 0;
  int          m_play      = 0;
  int          m_age       = 0;
  int          m_life      = 0;
  int          m_lock_left = 0;
  int          m_prev      = 0;
  logic [7:0]  m_mole      = '0;
  logic [7:0]  m_lock      = '0;
  logic [7:0]  m_btn_q     = '0;
  logic        m_start_q   = 1'b0;
  logic [15:0] m_lfsr      = 16'hACE1;

  mole_game_engine #(
    .NUM_HOLES   (NH),
    .SCORE_W     (SW),
    .GAME_CYCLES (GAME),
    .MOLE_CYCLES (MOLE),
    .LOCK_CYCLES (LOCK),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .btn       (btn),
    .level     (level),
    .mole      (mole),
    .lockout   (lockout),
    .score     (score),
    .misses    (misses),
    .game_over (game_over),
    .state_o   (state_o)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int idx_of(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < SMAX) ? v + 1 : SMAX;
  endfunction

  task automatic modelReset();
    m_state = 0; m_score = 0; m_misses = 0; m_play = 0; m_age = 0; m_life = 0;
    m_lock_left = 0; m_prev = 0; m_mole = '0; m_lock = '0; m_btn_q = '0;
    m_start_q = 1'b0; m_lfsr = 16'hACE1;
  endtask

  task automatic modelStep();
    logic       rise;
    logic [7:0] pr, lock_n;
    int         ll_n, cand;
    rise   = start & ~m_start_q;
    pr     = btn & ~m_btn_q & ~m_lock;
    lock_n = m_lock;
    ll_n   = m_lock_left;
    if (m_state != 3 && m_lock_left > 0) begin
      ll_n = m_lock_left - 1;
      if (ll_n == 0) lock_n = '0;
    end
    if ((m_state == 1 || m_state == 2) && m_play + 1 >= GAME) begin
      m_state = 3; m_mole = '0; lock_n = 8'hFF;
    end else if (rise) begin
      m_state = 1; m_score = 0; m_misses = 0; m_mole = '0;
      lock_n = '0; ll_n = 0; m_play = 0;
    end else if (m_state == 1) begin
      m_play++;
      cand = int'(m_lfsr) % 8;
      if (cand != m_prev) begin
        m_mole = 8'h01 << cand; m_prev = cand;
        m_life = MOLE >> level; m_age = 0; m_state = 2;
      end
    end else if (m_state == 2) begin
      m_play++;
      if ((pr & m_mole) != 0) begin
        m_score = sat_inc(m_score); m_mole = '0; m_state = 1;
      end else if (pr != 0) begin
        m_misses = sat_inc(m_misses); lock_n = m_lock | pr; ll_n = LOCK; m_age++;
      end else if (m_age + 1 >= m_life) begin
        m_misses = sat_inc(m_misses); m_mole = '0; m_state = 1;
      end else begin
        m_age++;
      end
    end
    m_lock      = lock_n;
    m_lock_left = ll_n;
    m_start_q   = start;
    m_btn_q     = btn;
    m_lfsr      = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  always @(negedge clk) begin
    checkOutput("state_o",   state_o,   m_state);
    checkOutput("mole",      mole,      m_mole);
    checkOutput("lockout",   lockout,   m_lock);
    checkOutput("score",     score,     m_score);
    checkOutput("misses",    misses,    m_misses);
    checkOutput("game_over", game_over, (m_state == 3) ? 1 : 0);
  end

  task automatic applyStimulus(input logic s, input logic [7:0] b, input logic [1:0] l);
    start = s;
    btn   = b;
    level = l;
    @(posedge clk);
    #2;
  endtask

  task automatic waitState(input int s, input logic [7:0] b, input logic [1:0] l,
                           input int limit, input string name);
    int n = 0;
    while (int'(state_o) != s && n < limit) begin
      applyStimulus(1'b0, b, l);
      n++;
    end
    checkOutput(name, state_o, s);
  endtask

  task automatic restartGame(input logic [1:0] l);
    applyStimulus(1'b0, 8'h00, l);
    applyStimulus(1'b1, 8'h00, l);
    applyStimulus(1'b0, 8'h00, l);
  endtask

  task automatic hitOnce(input logic [1:0] l);
    waitState(2, 8'h00, l, 50, "hit_wait_active");
    applyStimulus(1'b0, m_mole, l);
    applyStimulus(1'b0, 8'h00, l);
  endtask

  initial begin
    logic [7:0] last, hold, jb, b;
    logic [1:0] lv;
    logic       s;
    int         n, m0, held, r;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_state",   state_o,   0);
    checkOutput("reset_mole",    mole,      0);
    checkOutput("reset_lockout", lockout,   0);
    checkOutput("reset_score",   score,     0);
    checkOutput("reset_misses",  misses,    0);
    checkOutput("reset_over",    game_over, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 2'd0);
    checkOutput("idle_holds", state_o, 0);

    applyStimulus(1'b1, 8'h00, 2'd0);
    checkOutput("start_to_spawn", state_o, 1);
    applyStimulus(1'b0, 8'h00, 2'd0);
    waitState(2, 8'h00, 2'd0, 50, "first_active");
    checkOutput("first_mole_onehot", $onehot(mole), 1);

    restartGame(2'd0);
    last = '0;
    for (int i = 0; i < 50; i++) begin
      waitState(2, 8'h00, 2'd0, 50, "spawn_active");
      if (i > 0) checkOutput("mole_no_repeat", (mole == last) ? 1 : 0, 0);
      checkOutput("mole_onehot", $onehot(mole), 1);
      last = mole;
      applyStimulus(1'b0, m_mole, 2'd0);
      applyStimulus(1'b0, 8'h00, 2'd0);
    end

    restartGame(2'd0);
    waitState(2, 8'h00, 2'd0, 50, "hold_wait_active");
    hold = m_mole;
    applyStimulus(1'b0, hold, 2'd0);
    waitState(2, hold, 2'd0, 50, "held_respawn");
    repeat (3) applyStimulus(1'b0, hold, 2'd0);
    checkOutput("held_no_rescore", score, 1);
    checkOutput("held_no_miss", misses, 0);
    applyStimulus(1'b0, 8'h00, 2'd0);
    repeat (2) hitOnce(2'd0);
    checkOutput("three_hits_score", score, 3);
    checkOutput("three_hits_misses", misses, 0);
    repeat (2) hitOnce(2'd0);
    checkOutput("score_saturates", score, 3);

    restartGame(2'd0);
    waitState(2, 8'h00, 2'd0, 50, "wrong_wait_active");
    jb = 8'h01 << ((idx_of(m_mole) + 1) % 8);
    applyStimulus(1'b0, jb, 2'd0);
    checkOutput("wrong_misses", misses, 1);
    checkOutput("wrong_lockout", lockout, jb);
    checkOutput("wrong_stays_active", state_o, 2);
    n = ((lockout & jb) != 0) ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, (k == 1) ? jb : 8'h00, 2'd0);
      if (k == 1) checkOutput("locked_press_ignored", misses, 1);
      if ((lockout & jb) != 0) n++;
    end
    checkOutput("lockout_cycles", n, LOCK);

    waitState(1, 8'h00, 2'd2, 60, "timeout_to_spawn");
    waitState(2, 8'h00, 2'd2, 50, "level2_active");
    m0 = int'(misses);
    n = 0;
    while (mole != 0 && n < 20) begin
      n++;
      applyStimulus(1'b0, 8'h00, 2'd2);
    end
    checkOutput("level2_lifetime", n, 10);
    checkOutput("timeout_miss", misses, sat_inc(m0));

    n = 0;
    held = int'(score);
    while (state_o != 2'd3 && n < 500) begin
      held = int'(score);
      applyStimulus(1'b0, 8'h00, 2'd2);
      n++;
    end
    checkOutput("over_state", state_o, 3);
    checkOutput("over_flag", game_over, 1);
    checkOutput("over_lockout", lockout, 8'hFF);
    checkOutput("over_mole", mole, 0);
    checkOutput("over_score_held", score, held);
    repeat (5) applyStimulus(1'b0, 8'h00, 2'd2);
    checkOutput("over_still", game_over, 1);
    checkOutput("over_score_still", score, held);
    applyStimulus(1'b1, 8'h00, 2'd0);
    checkOutput("restart_state", state_o, 1);
    checkOutput("restart_score", score, 0);
    checkOutput("restart_misses", misses, 0);
    checkOutput("restart_lockout", lockout, 0);
    checkOutput("restart_over", game_over, 0);
    applyStimulus(1'b0, 8'h00, 2'd0);

    waitState(2, 8'h00, 2'd0, 50, "combo_wait_active");
    b = m_mole | (8'h01 << ((idx_of(m_mole) + 3) % 8));
    applyStimulus(1'b0, b, 2'd0);
    checkOutput("combo_score", score, 1);
    checkOutput("combo_misses", misses, 0);
    checkOutput("combo_lockout", lockout, 0);
    checkOutput("combo_to_spawn", state_o, 1);
    applyStimulus(1'b0, 8'h00, 2'd0);

    lv = 2'd0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_state",   state_o, 0);
        checkOutput("async_reset_score",   score,   0);
        checkOutput("async_reset_misses",  misses,  0);
        checkOutput("async_reset_mole",    mole,    0);
        checkOutput("async_reset_lockout", lockout, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
      r = $urandom_range(0, 9);
      s = (c == 0 || c == 2000 || $urandom_range(0, 199) == 0);
      if (c % 97 == 0) lv = 2'($urandom_range(0, 3));
      if (m_state == 2 && r < 3)
        b = m_mole | (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
      else if (r < 5) b = 8'($urandom);
      else if (r < 7) b = btn;
      else            b = 8'h00;
      applyStimulus(s, b, lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
